// File: rtl/sram_byte_phy_pkg.sv
// Shared types and constants for the byte-wide async SRAM PHY.
// The latency helpers give start-edge-to-pulse cycle counts for a given timing.
package sram_byte_phy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_RD_WAIT,
    ST_DONE
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam logic BYTE_LO = 1'b0;
  localparam logic BYTE_HI = 1'b1;

  // Controller keeps a fixed write window; completion latency must stay below it.
  localparam int unsigned CTRL_WINDOW = 60;

  function automatic int unsigned rd_latency(input int unsigned t_rd);
    return 2 * (1 + t_rd) + 1;
  endfunction

  function automatic int unsigned wr_latency(input int unsigned t_wp);
    return 2 * (t_wp + 2) + 1;
  endfunction

endpackage

// File: rtl/sram_byte_phy_if.sv
// Controller-facing request bus of the SRAM PHY (strobes, address, sample data, completion pulses).
interface sram_byte_phy_if;
  logic        ram_cen;
  logic        ram_oen;
  logic        ram_wen;
  logic [21:0] mem_block_addr;
  logic [3:0]  mem_bank;
  logic        write_zero;
  logic [15:0] wr_sample;
  logic [15:0] rd_sample;
  logic        read_data_valid;
  logic        wr_done;

  modport master (
    output ram_cen, ram_oen, ram_wen, mem_block_addr, mem_bank, write_zero, wr_sample,
    input  rd_sample, read_data_valid, wr_done
  );

  modport slave (
    input  ram_cen, ram_oen, ram_wen, mem_block_addr, mem_bank, write_zero, wr_sample,
    output rd_sample, read_data_valid, wr_done
  );
endinterface

// File: rtl/sram_byte_phy_timer.sv
// Loadable down-counter timing the WE-low pulse and the read access wait.
// Load has priority; the count stops at zero and o_zero flags it.
module sram_byte_phy_timer #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sram_byte_phy.sv
// Executes each controller request as two timed byte cycles (low then high) on an 8-bit async SRAM.
// All SRAM-side outputs are registered from the next-state decode so the strobes are glitch-free.
module sram_byte_phy
  import sram_byte_phy_pkg::*;
#(
  parameter int unsigned BLK_W = 14,
  parameter int unsigned T_RD  = 6,
  parameter int unsigned T_WP  = 7
) (
  input  logic             clk_100MHz,
  input  logic             rst,
  sram_byte_phy_if.slave   bus,
  output logic [BLK_W+4:0] sram_addr,
  output logic             sram_ce_n,
  output logic             sram_oe_n,
  output logic             sram_we_n,
  output logic [7:0]       sram_dq_o,
  output logic             sram_dq_oe,
  input  logic [7:0]       sram_dq_i
);

  localparam int unsigned T_MAX = (T_RD > T_WP) ? T_RD : T_WP;
  localparam int unsigned CNT_W = (T_MAX < 2) ? 1 : $clog2(T_MAX);

  state_e             r_state;
  op_e                r_op;
  logic               r_byte;
  logic               r_cen_q;
  logic [3:0]         r_bank;
  logic [BLK_W-1:0]   r_block;
  logic [15:0]        r_wdata;
  logic [15:0]        r_rd_buf;
  logic [15:0]        r_rd_sample;
  logic               r_rd_valid;
  logic               r_wr_done;
  logic [BLK_W+4:0]   r_addr;
  logic               r_ce_n;
  logic               r_oe_n;
  logic               r_we_n;
  logic [7:0]         r_dq_o;
  logic               r_dq_oe;

  state_e             w_state_nxt;
  logic               w_byte_nxt;
  op_e                w_op_nxt;
  logic [3:0]         w_bank_nxt;
  logic [BLK_W-1:0]   w_block_nxt;
  logic [15:0]        w_wdata_nxt;
  logic               w_start;
  logic               w_rd_cap;
  logic               w_pulse;
  logic               w_tmr_load;
  logic               w_tmr_en;
  logic [CNT_W-1:0]   w_tmr_val;
  logic               w_tmr_zero;
  logic               w_active_nxt;
  logic               w_drive_nxt;

  sram_byte_phy_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .i_clk      (clk_100MHz),
    .i_rst      (rst),
    .i_load     (w_tmr_load),
    .i_en       (w_tmr_en),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_byte_nxt  = r_byte;
    w_start     = 1'b0;
    w_rd_cap    = 1'b0;
    w_pulse     = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_en    = 1'b0;
    w_tmr_val   = '0;

    case (r_state)
      ST_IDLE: begin
        if (r_cen_q && !bus.ram_cen && (!bus.ram_wen || !bus.ram_oen)) begin
          w_start     = 1'b1;
          w_state_nxt = ST_SETUP;
          w_byte_nxt  = BYTE_LO;
        end
      end
      ST_SETUP: begin
        w_tmr_load = 1'b1;
        if (r_op == OP_WRITE) begin
          w_tmr_val   = CNT_W'(T_WP - 1);
          w_state_nxt = ST_WR_PULSE;
        end else begin
          w_tmr_val   = CNT_W'(T_RD - 1);
          w_state_nxt = ST_RD_WAIT;
        end
      end
      ST_WR_PULSE: begin
        w_tmr_en = 1'b1;
        if (w_tmr_zero) begin
          w_state_nxt = ST_WR_HOLD;
        end
      end
      ST_WR_HOLD: begin
        if (r_byte == BYTE_LO) begin
          w_state_nxt = ST_SETUP;
          w_byte_nxt  = BYTE_HI;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_RD_WAIT: begin
        w_tmr_en = 1'b1;
        if (w_tmr_zero) begin
          w_rd_cap = 1'b1;
          if (r_byte == BYTE_LO) begin
            w_state_nxt = ST_SETUP;
            w_byte_nxt  = BYTE_HI;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_pulse     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Controller withdrawing cen mid-transfer aborts; DONE is already committed.
    if ((r_state != ST_IDLE) && (r_state != ST_DONE) && bus.ram_cen) begin
      w_state_nxt = ST_IDLE;
      w_rd_cap    = 1'b0;
    end
  end

  always_comb begin
    w_op_nxt     = w_start ? ((!bus.ram_wen) ? OP_WRITE : OP_READ) : r_op;
    w_bank_nxt   = w_start ? bus.mem_bank : r_bank;
    w_block_nxt  = w_start ? bus.mem_block_addr[BLK_W-1:0] : r_block;
    w_wdata_nxt  = w_start ? (bus.write_zero ? 16'h0000 : bus.wr_sample) : r_wdata;
    w_active_nxt = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_WR_PULSE) ||
                   (w_state_nxt == ST_WR_HOLD) || (w_state_nxt == ST_RD_WAIT);
    w_drive_nxt  = w_active_nxt && (w_op_nxt == OP_WRITE);
  end

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_byte  <= BYTE_LO;
      r_cen_q <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_byte  <= w_byte_nxt;
      r_cen_q <= bus.ram_cen;
    end
  end

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      r_op        <= OP_READ;
      r_bank      <= '0;
      r_block     <= '0;
      r_wdata     <= '0;
      r_rd_buf    <= '0;
      r_rd_sample <= '0;
      r_rd_valid  <= 1'b0;
      r_wr_done   <= 1'b0;
      r_addr      <= '0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_dq_o      <= '0;
      r_dq_oe     <= 1'b0;
    end else begin
      r_op    <= w_op_nxt;
      r_bank  <= w_bank_nxt;
      r_block <= w_block_nxt;
      r_wdata <= w_wdata_nxt;
      r_ce_n  <= !w_active_nxt;
      r_oe_n  <= (w_state_nxt != ST_RD_WAIT);
      r_we_n  <= (w_state_nxt != ST_WR_PULSE);
      r_dq_oe <= w_drive_nxt;
      r_dq_o  <= w_drive_nxt ? ((w_byte_nxt == BYTE_HI) ? w_wdata_nxt[15:8] : w_wdata_nxt[7:0])
                             : 8'h00;
      if (w_active_nxt) begin
        r_addr <= {w_bank_nxt, w_block_nxt, w_byte_nxt};
      end
      if (w_rd_cap) begin
        if (r_byte == BYTE_LO) begin
          r_rd_buf[7:0] <= sram_dq_i;
        end else begin
          r_rd_buf[15:8] <= sram_dq_i;
        end
      end
      r_rd_valid <= w_pulse && (r_op == OP_READ);
      r_wr_done  <= w_pulse && (r_op == OP_WRITE);
      if (w_pulse && (r_op == OP_READ)) begin
        r_rd_sample <= r_rd_buf;
      end
    end
  end

  assign sram_addr           = r_addr;
  assign sram_ce_n           = r_ce_n;
  assign sram_oe_n           = r_oe_n;
  assign sram_we_n           = r_we_n;
  assign sram_dq_o           = r_dq_o;
  assign sram_dq_oe          = r_dq_oe;
  assign bus.rd_sample       = r_rd_sample;
  assign bus.read_data_valid = r_rd_valid;
  assign bus.wr_done         = r_wr_done;

endmodule

// File: tb/tb_sram_byte_phy.sv
// Directed bench for sram_byte_phy: table of read/write requests against a behavioural SRAM,
// plus hand-written ignore, abort and reset-mid-write sequences.
module tb_sram_byte_phy;

  localparam int unsigned BLK_W = 14;
  localparam int unsigned AW    = BLK_W + 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] sram_addr;
  logic          sram_ce_n, sram_oe_n, sram_we_n;
  logic [7:0]    sram_dq_o;
  logic          sram_dq_oe;
  logic [7:0]    sram_dq_i;

  sram_byte_phy_if bus ();

  sram_byte_phy #(
    .BLK_W(BLK_W),
    .T_RD (6),
    .T_WP (7)
  ) dut (
    .clk_100MHz (clk),
    .rst        (rst),
    .bus        (bus),
    .sram_addr  (sram_addr),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_i  (sram_dq_i)
  );

  always #5 clk = ~clk;

  logic [7:0]      mem [0:(1<<AW)-1];
  logic [AW+7:0]   wlog [$];
  int              n_checks = 0;
  int              n_pass   = 0;
  int              n_overlap = 0;

  assign sram_dq_i = (!sram_oe_n && !sram_ce_n) ? mem[sram_addr] : 8'h00;

  always @(posedge sram_we_n) begin
    if (!sram_ce_n && sram_dq_oe) begin
      mem[sram_addr] = sram_dq_o;
      wlog.push_back({sram_addr, sram_dq_o});
    end
  end

  always @(negedge clk) begin
    if (!sram_oe_n && !sram_we_n) n_overlap++;
    if (sram_dq_oe && !sram_oe_n) n_overlap++;
  end

  typedef struct {
    logic          oen;
    logic          wen;
    logic          wz;
    logic [15:0]   wdata;
    logic [3:0]    bank;
    logic [21:0]   block;
    logic          pre;
    logic [7:0]    lo;
    logic [7:0]    hi;
    logic [AW-1:0] addr;
    logic [15:0]   rd;
    int            lat;
  } vec_t;

  vec_t vecs [6];
  vec_t v_rst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [3:0] strobes();
    return {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe};
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    int            cyc, oe_low, we_low, wrong;
    logic          seen, got_addr, is_wr;
    logic [AW-1:0] first_addr;
    is_wr = !v.wen;
    if (v.pre) begin
      mem[v.addr]     = is_wr ? 8'hAA : v.lo;
      mem[v.addr | 1] = is_wr ? 8'h55 : v.hi;
    end
    wlog.delete();
    bus.ram_cen = 1'b1;
    @(posedge clk); #1;
    bus.ram_cen        = 1'b0;
    bus.ram_oen        = v.oen;
    bus.ram_wen        = v.wen;
    bus.write_zero     = v.wz;
    bus.wr_sample      = v.wdata;
    bus.mem_bank       = v.bank;
    bus.mem_block_addr = v.block;
    @(posedge clk); #1;
    cyc = 0; oe_low = 0; we_low = 0; wrong = 0; seen = 1'b0; got_addr = 1'b0; first_addr = '0;
    while (!seen && cyc < 60) begin
      if (!sram_ce_n && !got_addr) begin first_addr = sram_addr; got_addr = 1'b1; end
      if (!sram_oe_n) oe_low++;
      if (!sram_we_n) we_low++;
      @(posedge clk); #1;
      cyc++;
      if (is_wr ? bus.read_data_valid : bus.wr_done) wrong++;
      if (is_wr ? bus.wr_done : bus.read_data_valid) seen = 1'b1;
    end
    check({tag, " latency"}, seen ? cyc : -1, v.lat);
    check({tag, " rd_sample"}, bus.rd_sample, v.rd);
    bus.ram_cen = 1'b1;
    bus.ram_oen = 1'b1;
    bus.ram_wen = 1'b1;
    @(posedge clk); #1;
    check({tag, " pulse width"}, {bus.read_data_valid, bus.wr_done}, 2'b00);
    check({tag, " wrong pulse"}, wrong, 0);
    check({tag, " first addr"}, first_addr, v.addr);
    check({tag, " oe_n low cycles"}, oe_low, is_wr ? 0 : 12);
    check({tag, " we_n low cycles"}, we_low, is_wr ? 14 : 0);
    if (is_wr) begin
      check({tag, " mem lo"}, mem[v.addr], v.lo);
      check({tag, " mem hi"}, mem[v.addr | 1], v.hi);
      check({tag, " write count"}, wlog.size(), 2);
      if (wlog.size() > 0) check({tag, " first write"}, wlog[0], {v.addr, v.lo});
    end
  endtask

  initial begin
    int ce_low, pulses, found;

    //          oen   wen   wz    wdata     bank   block        pre   lo     hi     addr       rd        lat
    vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'd3,  22'h000012, 1'b1, 8'h34, 8'h12, 19'h18024, 16'h1234, 15};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 16'hBEEF, 4'd15, 22'h003FFF, 1'b0, 8'hEF, 8'hBE, 19'h7FFFE, 16'h1234, 19};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 16'hFFFF, 4'd2,  22'h000100, 1'b1, 8'h00, 8'h00, 19'h10200, 16'h1234, 19};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 16'h5A3C, 4'd1,  22'h000007, 1'b1, 8'h3C, 8'h5A, 19'h0800E, 16'h1234, 19};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'd15, 22'h007FFF, 1'b0, 8'hEF, 8'hBE, 19'h7FFFE, 16'hBEEF, 15};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'd0,  22'h3FC000, 1'b1, 8'hA5, 8'h5A, 19'h00000, 16'h5AA5, 15};
    v_rst   = '{1'b1, 1'b0, 1'b0, 16'h1357, 4'd4,  22'h000055, 1'b1, 8'h57, 8'h13, 19'h200AA, 16'h0000, 19};

    bus.ram_cen = 1'b1; bus.ram_oen = 1'b1; bus.ram_wen = 1'b1;
    bus.write_zero = 1'b0; bus.wr_sample = '0; bus.mem_bank = '0; bus.mem_block_addr = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset strobes", strobes(), 4'b1110);
    check("reset addr", sram_addr, 0);
    check("reset dq_o", sram_dq_o, 0);
    check("reset rd_sample", bus.rd_sample, 0);
    check("reset pulses", {bus.read_data_valid, bus.wr_done}, 2'b00);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_vec($sformatf("v%0d", i), vecs[i]);
    end

    // cen falls with neither oen nor wen low: nothing happens
    @(posedge clk); #1;
    bus.ram_cen = 1'b0;
    ce_low = 0; pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (!sram_ce_n) ce_low++;
      if (bus.read_data_valid || bus.wr_done) pulses++;
    end
    check("ignore ce_n low", ce_low, 0);
    check("ignore pulses", pulses, 0);
    bus.ram_cen = 1'b1;

    // abort a read 5 cycles after start
    mem[0] = 8'h11; mem[1] = 8'h22;
    @(posedge clk); #1;
    bus.ram_cen = 1'b0; bus.ram_oen = 1'b0; bus.ram_wen = 1'b1;
    bus.mem_bank = 4'd0; bus.mem_block_addr = '0;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    check("abort active before", sram_oe_n, 1'b0);
    bus.ram_cen = 1'b1; bus.ram_oen = 1'b1;
    @(posedge clk); #1;
    check("abort strobes", strobes(), 4'b1110);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (bus.read_data_valid || bus.wr_done) pulses++;
    end
    check("abort pulses", pulses, 0);
    check("abort rd_sample", bus.rd_sample, 16'h5AA5);

    // reset asserted during WR_PULSE
    bus.ram_cen = 1'b0; bus.ram_oen = 1'b1; bus.ram_wen = 1'b0;
    bus.write_zero = 1'b0; bus.wr_sample = 16'hCAFE;
    bus.mem_bank = 4'd5; bus.mem_block_addr = 22'h000033;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(posedge clk); #1;
      if (!sram_we_n) found = 1;
    end
    check("reset-test reached WR_PULSE", found, 1);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    bus.ram_cen = 1'b1; bus.ram_wen = 1'b1;
    #1;
    check("reset mid-op strobes", strobes(), 4'b1110);
    check("reset mid-op dq_o", sram_dq_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (bus.wr_done || bus.read_data_valid) pulses++;
    end
    check("reset mid-op pulses", pulses, 0);
    run_vec("after-reset", v_rst);

    check("oe/we/dq_oe overlap", n_overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
